// File: rtl/m_mem_master.sv
// m_mem_master: memory-stage load/store initiator for the pipelined MIPS core.
// Turns one M-stage access into a valid/ready request plus a response on the
// data bus, shapes byte enables and write data, extends load data, and holds
// the pipeline until the access completes, faults on misalignment, or times out.
module m_mem_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // Last counter value that may still complete normally; at or beyond it we give up.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        req_valid_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  ltype_q;
    logic [1:0]  off_q;

    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Decode the incoming access: alignment fault, byte enables and lane-replicated data
    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'hF;
        wdata_d    = cpu_wdata;
        if (cpu_we) begin
            case (store_type)
                2'd1: begin
                    be_d    = 4'b0001 << cpu_addr[1:0];
                    wdata_d = {4{cpu_wdata[7:0]}};
                end
                2'd2: begin
                    be_d       = cpu_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d    = {2{cpu_wdata[15:0]}};
                    misaligned = cpu_addr[0];
                end
                default: misaligned = |cpu_addr[1:0];
            endcase
        end else begin
            case (load_type)
                3'd1, 3'd2: misaligned = 1'b0;
                3'd3, 3'd4: misaligned = cpu_addr[0];
                default:    misaligned = |cpu_addr[1:0];
            endcase
        end
    end

    // Pick the addressed byte/half out of the raw response word and extend it
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ltype_q)
            3'd1:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    load_ext = {24'h0, ld_byte};
            3'd3:    load_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    load_ext = {16'h0, ld_half};
            default: load_ext = bus_rdata;
        endcase
        // Store acknowledges carry no data back to the pipeline.
        if (we_q) begin
            load_ext = '0;
        end
    end

    // Transaction sequencer: latch the access, run the bus handshake, produce the completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            ltype_q     <= '0;
            off_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        if (misaligned) begin
                            // Fault without touching the bus.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                            addr_q      <= {cpu_addr[31:2], 2'b00};
                            we_q        <= cpu_we;
                            be_q        <= be_d;
                            wdata_q     <= wdata_d;
                            ltype_q     <= load_type;
                            off_q       <= cpu_addr[1:0];
                            cnt_q       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                        cnt_q       <= cnt_q + 8'd1;
                    end else if (cnt_q >= TO_LAST) begin
                        req_valid_q <= 1'b0;
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        rdata_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT: begin
                    // A response on the timeout cycle still wins.
                    if (bus_rsp_valid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= load_ext;
                    end else if (cnt_q >= TO_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    // Pipeline advances on this edge, so the held cpu_valid is stale here.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall         = (state_q == REQ) | (state_q == WAIT) | ((state_q == IDLE) & cpu_valid);
    assign done          = done_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign bus_req_valid = req_valid_q;
    assign bus_addr      = addr_q;
    assign bus_we        = we_q;
    assign bus_be        = be_q;
    assign bus_wdata     = wdata_q;

endmodule

// File: doc/m_mem_master.md
# m_mem_master

Memory-stage bus initiator for the pipelined MIPS core. It takes one load/store per instruction from the M stage and runs it as a valid/ready request plus response transaction on the data-memory bus. It generates byte enables and lane-replicated write data, and sign- or zero-extends returned load data. It stalls the pipeline until the access completes, faults on misalignment, or times out.

## Interface
- `TIMEOUT`, default 255: maximum cycles from request issue to response before an error completion; range 1..255.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; returns every register to its reset value immediately.
- `cpu_valid` input 1: M-stage instruction is a load or store; held until `done`.
- `cpu_we` input 1: 1 = store, 0 = load.
- `cpu_addr` input 32: byte address.
- `cpu_wdata` input 32: store data (low byte/half used for sb/sh).
- `load_type` input 3: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; other codes behave as lw.
- `store_type` input 2: 0 sw, 1 sb, 2 sh; 3 behaves as sw.
- `stall` output 1: freeze F/D/E/M stages.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; misaligned access or timeout.
- `rdata` output 32: extended load result, valid with `done` and held until the next `done`.
- `bus_req_valid` output 1: request valid.
- `bus_req_ready` input 1: memory accepts request.
- `bus_addr` output 32: word address, `{cpu_addr[31:2],2'b00}`.
- `bus_we` output 1: write request.
- `bus_be` output 4: byte enables.
- `bus_wdata` output 32: lane-replicated write data.
- `bus_rsp_valid` input 1: response (load data or store acknowledge).
- `bus_rdata` input 32: raw word read.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - `cpu_valid` and aligned: latch the request, drive the bus registers, go to REQ.
  - `cpu_valid` and misaligned: go to DONE with `err=1` and `rdata=0`. No bus transaction is issued.
  - Misaligned means lw/sw with `addr[1:0]!=0`, or lh/lhu/sh with `addr[0]!=0`.
- REQ: `bus_req_valid=1`. Address, write enable, byte enables and write data stay stable until `bus_req_ready`. On `bus_req_ready` go to WAIT.
- WAIT: on `bus_rsp_valid`, register the extended `rdata` (0 for stores) and go to DONE with `err=0`.
- DONE: `done=1` for one cycle, then unconditionally return to IDLE. The pipeline advances at this edge, so the held `cpu_valid` does not re-trigger.
- Byte enables:
  - Loads and sw: 1111.
  - sb: `4'b0001 << addr[1:0]`.
  - sh: `addr[1]` ? 1100 : 0011.
- Write data:
  - sw: `cpu_wdata`.
  - sb: `{4{cpu_wdata[7:0]}}`.
  - sh: `{2{cpu_wdata[15:0]}}`.
- Load extraction from `bus_rdata`:
  - lb/lbu: byte `addr[1:0]`, sign- or zero-extended to 32 bits.
  - lh/lhu: half `addr[1]`, sign- or zero-extended.
  - lw: full word.
- Timeout:
  - An 8-bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` without completion, go to DONE with `err=1` and `rdata=0`, and drop `bus_req_valid`.
- Responses arriving in IDLE, REQ or DONE are ignored.
- `stall` (combinational) = `(state==REQ)|(state==WAIT)|(state==IDLE & cpu_valid)`. It is 0 in DONE.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `bus_req_valid`, `bus_we`, `done`, `err` = 0.
  - `bus_be`, `bus_addr`, `bus_wdata`, `rdata` = 0.
  - `stall` follows `cpu_valid`.
- Zero-wait memory (ready=1, response one cycle after the handshake):
  - Request seen in cycle N.
  - Handshake in N+1.
  - Response in N+2.
  - `done` in N+3.
  - `stall` high N..N+2.
- Minimum access latency is 3 cycles; each ready or response wait cycle adds one.
- `bus_req_valid` is never withdrawn before `bus_req_ready`, except on timeout or reset.
- Misaligned access: `done`/`err` in N+1; `stall` high only in N.
- Reset mid-transaction: IDLE immediately, `bus_req_valid` low in the same cycle, and no `done` pulse.
- Back-to-back accesses: the next request can be accepted in the cycle after DONE.

## Test plan
- lw at 0x0000_0010, ready=1, `bus_rdata`=0x8765_4321 -> `bus_be`=1111, `done` at N+3, `rdata`=0x8765_4321, `err`=0, `stall` high for 3 cycles.
- lb/lbu at 0x13 with `bus_rdata`=0x80FF_1234 -> `bus_be`=1111, lb `rdata`=0xFFFF_FF80, lbu `rdata`=0x0000_0080; lh at 0x12 -> 0xFFFF_80FF.
- sb at 0x21 with data 0xAB, then sh at 0x22 with data 0xBEEF -> `bus_be`=0010 / `bus_wdata`=0xABABABAB, then `bus_be`=1100 / `bus_wdata`=0xBEEFBEEF; `bus_addr`=0x20 for both.
- `bus_req_ready` held low for 4 cycles -> `bus_req_valid` and `bus_addr` stable for all 5 cycles, `done` at N+7.
- lw at 0x02 -> no `bus_req_valid`, `done`=`err`=1 at N+1; with `TIMEOUT`=8 and no response -> `err`=1 and `rdata`=0 on timeout.
- `reset` asserted during WAIT, then a stray `bus_rsp_valid` -> state IDLE, no `done`, outputs at reset values.
